// File: rtl/serial_rx_frame.sv
// Serial bit-stream receiver: assembles LSB-first words, buffers them in a FIFO and flags frame ends.
// Optional even-parity checking per word is enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx_frame #(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic              tx_data,
  output logic              rx_ready,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_word_valid,
  input  logic              rx_word_ready,
  output logic              rx_finish,
  output logic              rx_overflow,
  output logic              rx_parity_err
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned BITS_W = WORD_W + PAR_W;
  localparam int unsigned BCNT_W = $clog2(BITS_W);
  localparam int unsigned WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(BITS_W - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [WCNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [BITS_W-1:0] shreg, assembled;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WORD_W-1:0] head_nxt;
  logic              bit_fire, word_done, parity_ok, push, pop, frame_end;

  // Next-state, datapath and FIFO bookkeeping
  always_comb begin
    bit_fire   = tx_valid && rx_ready;
    assembled  = shreg;
    assembled[bit_cnt] = tx_data;
    word_done  = bit_fire && (bit_cnt == LAST_BIT);
`ifdef SERIAL_RX_PARITY_EN
    parity_ok  = ~(^assembled);
`else
    parity_ok  = 1'b1;
`endif
    push       = word_done && parity_ok;
    pop        = rx_word_valid && rx_word_ready;
    frame_end  = push && (word_cnt == LAST_WORD);

    bit_cnt_nxt = bit_cnt;
    if (bit_fire) bit_cnt_nxt = word_done ? '0 : bit_cnt + BCNT_W'(1);

    word_cnt_nxt = word_cnt;
    if (push) word_cnt_nxt = frame_end ? '0 : word_cnt + WCNT_W'(1);

    wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

    // A word written this edge into the slot that becomes the head bypasses the array
    head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? assembled[WORD_W-1:0] : mem[rd_ptr_nxt];

    state_nxt = state;
    case (state)
      IDLE:    if (bit_fire) state_nxt = RECV;
      RECV:    if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      shreg         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rx_ready      <= 1'b0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_finish     <= 1'b0;
      rx_overflow   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      word_cnt      <= word_cnt_nxt;
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      if (bit_fire) shreg <= assembled;
      if (push) mem[wr_ptr] <= assembled[WORD_W-1:0];
      rx_word       <= head_nxt;
      rx_word_valid <= (count_nxt != '0);
      rx_finish     <= (state_nxt == DONE);
      rx_ready      <= (count_nxt != FULL_CNT) && (state_nxt != DONE);
      if (tx_valid && !rx_ready) rx_overflow <= 1'b1;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_parity_err <= 1'b0;
    else     rx_parity_err <= word_done && !parity_ok;
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench for serial_rx_frame: default instance plus a 12-bit/2-word/8-deep instance.
module tb_serial_rx_frame;

`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0, tx_data = 1'b0, rx_word_ready = 1'b0;
  logic        rx_ready, rx_word_valid, rx_finish, rx_overflow, rx_parity_err;
  logic [7:0]  rx_word;
  logic        b_tx_valid = 1'b0, b_tx_data = 1'b0, b_rx_word_ready = 1'b1;
  logic        b_rx_ready, b_rx_word_valid, b_rx_finish, b_rx_overflow, b_rx_parity_err;
  logic [11:0] b_rx_word;

  int vec = 0, errs = 0, cyc = 0;
  int fin_a = 0, perr_a = 0;
  logic [7:0]  fin_word_a;
  logic [7:0]  got_a[$];
  logic [11:0] got_b[$];
  int          fin_cyc_b[$];

  serial_rx_frame dut_a (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .rx_ready(rx_ready),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid), .rx_word_ready(rx_word_ready),
    .rx_finish(rx_finish), .rx_overflow(rx_overflow), .rx_parity_err(rx_parity_err));

  serial_rx_frame #(.WORD_W(12), .FRAME_WORDS(2), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_data(b_tx_data), .rx_ready(b_rx_ready),
    .rx_word(b_rx_word), .rx_word_valid(b_rx_word_valid), .rx_word_ready(b_rx_word_ready),
    .rx_finish(b_rx_finish), .rx_overflow(b_rx_overflow), .rx_parity_err(b_rx_parity_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Passive monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_word_valid && rx_word_ready) got_a.push_back(rx_word);
      if (rx_finish) begin fin_a++; fin_word_a = rx_word; end
      if (rx_parity_err) perr_a++;
      if (b_rx_word_valid && b_rx_word_ready) got_b.push_back(b_rx_word);
      if (b_rx_finish) fin_cyc_b.push_back(cyc);
    end
  end

  task automatic clear_logs();
    got_a.delete(); got_b.delete(); fin_cyc_b.delete();
    fin_a = 0; perr_a = 0;
  endtask

  task automatic do_reset();
    tx_valid = 1'b0; b_tx_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic send_bit_a(input logic b);
    int waited = 0;
    while (!rx_ready && waited < 200) begin
      tx_valid = 1'b0; @(posedge clk); #1; waited++;
    end
    if (!rx_ready) begin
      vec++; errs++; $display("FAIL send_bit_a timeout: rx_ready=%b required 1", rx_ready);
    end
    tx_valid = 1'b1; tx_data = b;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic send_word_a(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit_a(w[i]);
    if (PB == 1) send_bit_a(^w);
  endtask

  task automatic send_bit_b(input logic b);
    int waited = 0;
    while (!b_rx_ready && waited < 200) begin
      b_tx_valid = 1'b0; @(posedge clk); #1; waited++;
    end
    if (!b_rx_ready) begin
      vec++; errs++; $display("FAIL send_bit_b timeout: rx_ready=%b required 1", b_rx_ready);
    end
    b_tx_valid = 1'b1; b_tx_data = b;
    @(posedge clk); #1;
    b_tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vec++; if (rx_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", rx_ready); end
    vec++; if (rx_word_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", rx_word_valid); end
    vec++; if (rx_finish !== 1'b0) begin errs++; $display("FAIL reset_finish got=%b exp=0", rx_finish); end
    vec++; if (rx_overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow got=%b exp=0", rx_overflow); end
    vec++; if (rx_parity_err !== 1'b0) begin errs++; $display("FAIL reset_parity got=%b exp=0", rx_parity_err); end
    vec++; if (rx_word !== 8'h00) begin errs++; $display("FAIL reset_word got=%h exp=00", rx_word); end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    vec++; if (rx_ready !== 1'b0) begin errs++; $display("FAIL ready_before_edge got=%b exp=0", rx_ready); end
    @(posedge clk); #1;
    vec++; if (rx_ready !== 1'b1) begin errs++; $display("FAIL ready_after_edge got=%b exp=1", rx_ready); end
    clear_logs();
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp [4] = '{8'hD5, 8'h33, 8'hAA, 8'hF0};
    logic [7:0] obs;
    rx_word_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_word_a(exp[i]);
    repeat (5) @(posedge clk); #1;
    vec++; if (got_a.size() !== 4) begin errs++; $display("FAIL basic_count got=%0d exp=4", got_a.size()); end
    for (int i = 0; i < 4; i++) begin
      obs = (i < got_a.size()) ? got_a[i] : 8'hxx;
      vec++; if (obs !== exp[i]) begin errs++; $display("FAIL basic_word%0d got=%h exp=%h", i, obs, exp[i]); end
    end
    vec++; if (fin_a !== 1) begin errs++; $display("FAIL basic_finish_count got=%0d exp=1", fin_a); end
    vec++; if (fin_word_a !== 8'hF0) begin errs++; $display("FAIL basic_finish_word got=%h exp=F0", fin_word_a); end
    vec++; if (rx_overflow !== 1'b0) begin errs++; $display("FAIL basic_overflow got=%b exp=0", rx_overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] obs;
    do_reset();
    rx_word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word_a(exp[i]);
    repeat (2) @(posedge clk); #1;
    vec++; if (rx_ready !== 1'b0) begin errs++; $display("FAIL ovf_ready_full got=%b exp=0", rx_ready); end
    vec++; if (rx_word !== 8'h11) begin errs++; $display("FAIL ovf_head got=%h exp=11", rx_word); end
    tx_valid = 1'b1; tx_data = 1'b1;
    repeat (8 + PB) @(posedge clk);
    #1 tx_valid = 1'b0;
    @(posedge clk); #1;
    vec++; if (rx_overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b exp=1", rx_overflow); end
    vec++; if (rx_word !== 8'h11) begin errs++; $display("FAIL ovf_head_stable got=%h exp=11", rx_word); end
    rx_word_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    vec++; if (got_a.size() !== 4) begin errs++; $display("FAIL ovf_count got=%0d exp=4", got_a.size()); end
    for (int i = 0; i < 4; i++) begin
      obs = (i < got_a.size()) ? got_a[i] : 8'hxx;
      vec++; if (obs !== exp[i]) begin errs++; $display("FAIL ovf_word%0d got=%h exp=%h", i, obs, exp[i]); end
    end
    vec++; if (rx_ready !== 1'b1) begin errs++; $display("FAIL ovf_ready_drained got=%b exp=1", rx_ready); end
    vec++; if (rx_overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got=%b exp=1", rx_overflow); end
  endtask

  task automatic test_stall();
    logic [7:0] w = 8'h5A;
    logic [7:0] obs;
    do_reset();
    rx_word_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit_a(w[i]);
    tx_valid = 1'b0;
    repeat (20) @(posedge clk); #1;
    vec++; if (rx_word_valid !== 1'b0) begin errs++; $display("FAIL stall_partial_valid got=%b exp=0", rx_word_valid); end
    for (int i = 4; i < 8; i++) send_bit_a(w[i]);
    if (PB == 1) send_bit_a(^w);
    repeat (3) @(posedge clk); #1;
    vec++; if (got_a.size() !== 1) begin errs++; $display("FAIL stall_count got=%0d exp=1", got_a.size()); end
    obs = (got_a.size() > 0) ? got_a[0] : 8'hxx;
    vec++; if (obs !== 8'h5A) begin errs++; $display("FAIL stall_word got=%h exp=5A", obs); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] obs;
    do_reset();
    rx_word_ready = 1'b0;
    send_word_a(8'h01);
    send_bit_a(1'b0); send_bit_a(1'b1); send_bit_a(1'b0);
    vec++; if (rx_word_valid !== 1'b1) begin errs++; $display("FAIL mid_prevalid got=%b exp=1", rx_word_valid); end
    #2 rst = 1'b1;
    #1;
    vec++; if (rx_word_valid !== 1'b0) begin errs++; $display("FAIL mid_valid got=%b exp=0", rx_word_valid); end
    vec++; if (rx_word !== 8'h00) begin errs++; $display("FAIL mid_word got=%h exp=00", rx_word); end
    vec++; if (rx_ready !== 1'b0) begin errs++; $display("FAIL mid_ready got=%b exp=0", rx_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    rx_word_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_word_a(exp[i]);
    repeat (5) @(posedge clk); #1;
    vec++; if (got_a.size() !== 4) begin errs++; $display("FAIL mid_count got=%0d exp=4", got_a.size()); end
    for (int i = 0; i < 4; i++) begin
      obs = (i < got_a.size()) ? got_a[i] : 8'hxx;
      vec++; if (obs !== exp[i]) begin errs++; $display("FAIL mid_word%0d got=%h exp=%h", i, obs, exp[i]); end
    end
    vec++; if (fin_a !== 1) begin errs++; $display("FAIL mid_finish got=%0d exp=1", fin_a); end
  endtask

  task automatic test_parity();
    logic [7:0] obs;
    do_reset();
    rx_word_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit_a(i < 3);
    send_bit_a(1'b0);
    for (int i = 0; i < 8; i++) send_bit_a(i < 3);
    send_bit_a(1'b1);
    repeat (3) @(posedge clk); #1;
    vec++; if (perr_a !== 1) begin errs++; $display("FAIL parity_err_count got=%0d exp=1", perr_a); end
    vec++; if (got_a.size() !== 1) begin errs++; $display("FAIL parity_count got=%0d exp=1", got_a.size()); end
    obs = (got_a.size() > 0) ? got_a[0] : 8'hxx;
    vec++; if (obs !== 8'h07) begin errs++; $display("FAIL parity_word got=%h exp=07", obs); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp [4] = '{12'hABC, 12'h123, 12'hFED, 12'h456};
    logic [11:0] obs;
    int gap;
    do_reset();
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 12; i++) send_bit_b(exp[w][i]);
      if (PB == 1) send_bit_b(^exp[w]);
    end
    repeat (5) @(posedge clk); #1;
    vec++; if (got_b.size() !== 4) begin errs++; $display("FAIL b2b_count got=%0d exp=4", got_b.size()); end
    for (int i = 0; i < 4; i++) begin
      obs = (i < got_b.size()) ? got_b[i] : 12'hxxx;
      vec++; if (obs !== exp[i]) begin errs++; $display("FAIL b2b_word%0d got=%h exp=%h", i, obs, exp[i]); end
    end
    vec++; if (fin_cyc_b.size() !== 2) begin errs++; $display("FAIL b2b_finish_count got=%0d exp=2", fin_cyc_b.size()); end
    gap = (fin_cyc_b.size() == 2) ? fin_cyc_b[1] - fin_cyc_b[0] : -1;
    vec++; if (gap !== 2 * (12 + PB) + 1) begin errs++; $display("FAIL b2b_finish_gap got=%0d exp=%0d", gap, 2 * (12 + PB) + 1); end
    vec++; if (b_rx_overflow !== 1'b0) begin errs++; $display("FAIL b2b_overflow got=%b exp=0", b_rx_overflow); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_stall();
    test_reset_mid();
    if (PB == 1) test_parity();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
